// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: board-level run controller for the RV32I core.
// Turns the run/step/pause push buttons into a CPU clock-enable with
// free-run, single-step, pause and PC-breakpoint halt modes.
module debug_run_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_WIDTH  = 20,
  parameter int PC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_run,
  input  logic                btn_step,
  input  logic                btn_pause,
  input  logic                bp_en,
  input  logic [PC_WIDTH-1:0] bp_addr,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                cpu_en,
  output logic [1:0]          state,
  output logic                bp_hit,
  output logic [31:0]         exec_cnt
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } run_state_e;

  localparam int BTN_PAUSE = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_RUN   = 2;

  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_CYCLES - 1);
  localparam logic [DB_WIDTH-1:0] DB_ONE  = {{(DB_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]  btn_raw_s;
  logic [2:0]  pulse_s;
  logic        hit_s;
  logic        go_s;
  logic        cpu_en_s;
  run_state_e  state_r;
  logic        armed_r;
  logic [31:0] exec_cnt_r;

  assign btn_raw_s = {btn_run, btn_step, btn_pause};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic                sync1_r;
    logic                sync2_r;
    logic                level_r;
    logic                level_dly_r;
    logic                pulse_r;
    logic [DB_WIDTH-1:0] cnt_r;

    // Synchronise, debounce and rising-edge detect one raw button level
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_r     <= 1'b0;
        sync2_r     <= 1'b0;
        level_r     <= 1'b0;
        level_dly_r <= 1'b0;
        pulse_r     <= 1'b0;
        cnt_r       <= {DB_WIDTH{1'b0}};
      end else begin
        sync1_r <= btn_raw_s[g];
        sync2_r <= sync1_r;
        if (sync2_r == level_r) begin
          cnt_r <= {DB_WIDTH{1'b0}};
        end else if (cnt_r == DB_LAST) begin
          level_r <= sync2_r;
          cnt_r   <= {DB_WIDTH{1'b0}};
        end else begin
          cnt_r <= cnt_r + DB_ONE;
        end
        level_dly_r <= level_r;
        pulse_r     <= level_r & ~level_dly_r;
      end
    end

    assign pulse_s[g] = pulse_r;
  end

  // armed suppresses an immediate re-halt when resuming at the breakpoint PC
  assign hit_s = bp_en & armed_r & (pc == bp_addr);

  // Detect a transition into RUN or STEP from a stopped state
  always_comb begin
    go_s = 1'b0;
    if ((state_r == ST_PAUSE) || (state_r == ST_BREAK)) begin
      go_s = ~pulse_s[BTN_PAUSE] & (pulse_s[BTN_STEP] | pulse_s[BTN_RUN]);
    end else begin
      go_s = 1'b0;
    end
  end

  // Clock-enable decode: the breakpoint instruction itself is never executed
  always_comb begin
    cpu_en_s = 1'b0;
    case (state_r)
      ST_RUN:  cpu_en_s = ~hit_s;
      ST_STEP: cpu_en_s = 1'b1;
      default: cpu_en_s = 1'b0;
    endcase
  end

  // Run-control FSM, breakpoint arming and executed-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_PAUSE;
      armed_r    <= 1'b1;
      exec_cnt_r <= 32'h0000_0000;
    end else begin
      if (cpu_en_s) begin
        exec_cnt_r <= exec_cnt_r + 32'd1;
      end else begin
        exec_cnt_r <= exec_cnt_r;
      end

      if (pc != bp_addr) begin
        armed_r <= 1'b1;
      end else if (go_s) begin
        armed_r <= 1'b0;
      end else begin
        armed_r <= armed_r;
      end

      case (state_r)
        ST_PAUSE, ST_BREAK: begin
          if (pulse_s[BTN_PAUSE]) begin
            state_r <= ST_PAUSE;
          end else if (pulse_s[BTN_STEP]) begin
            state_r <= ST_STEP;
          end else if (pulse_s[BTN_RUN]) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= state_r;
          end
        end
        ST_RUN: begin
          if (pulse_s[BTN_PAUSE]) begin
            state_r <= ST_PAUSE;
          end else if (hit_s) begin
            state_r <= ST_BREAK;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_STEP: state_r <= ST_PAUSE;
        default: state_r <= ST_PAUSE;
      endcase
    end
  end

  assign cpu_en   = cpu_en_s;
  assign state    = state_r;
  assign bp_hit   = (state_r == ST_BREAK);
  assign exec_cnt = exec_cnt_r;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Self-checking bench for debug_run_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized buttons against a behavioural model.
module tb_debug_run_ctrl;

  localparam int          DB      = 4;
  localparam logic [31:0] PC_MASK = 32'h0000_001C;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_run, btn_step, btn_pause, bp_en;
  logic [31:0] bp_addr, pc;
  logic        cpu_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] exec_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debug_run_ctrl #(.DB_CYCLES(DB), .DB_WIDTH(4), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .btn_pause(btn_pause), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .exec_cnt(exec_cnt)
  );

  // ---------------- behavioural reference model ----------------
  int          m_mode;       // 0 pause, 1 run, 2 step, 3 break
  bit          m_armed;
  logic [31:0] m_exec;
  logic [31:0] m_pc;
  logic [2:0]  m_pipe[$];    // raw samples awaiting the two-flop delay
  bit          m_level[3];
  int          m_agree_run[3];
  bit          m_rose[3];
  bit          m_pulse[3];   // index 0 pause, 1 step, 2 run

  task automatic model_reset();
    m_mode = 0; m_armed = 1'b1; m_exec = 32'd0; m_pc = 32'd0;
    m_pipe.delete();
    m_pipe.push_back(3'b000);
    m_pipe.push_back(3'b000);
    for (int b = 0; b < 3; b++) begin
      m_level[b] = 1'b0; m_agree_run[b] = 0; m_rose[b] = 1'b0; m_pulse[b] = 1'b0;
    end
  endtask

  function automatic bit m_hit();
    return bp_en && m_armed && (pc == bp_addr);
  endfunction

  function automatic bit m_en();
    return (m_mode == 2) || (m_mode == 1 && !m_hit());
  endfunction

  task automatic model_edge();
    int         nxt;
    bit         en;
    logic [2:0] seen;
    en  = m_en();
    nxt = m_mode;
    if (m_mode == 0 || m_mode == 3) begin
      if (m_pulse[0])      nxt = 0;
      else if (m_pulse[1]) nxt = 2;
      else if (m_pulse[2]) nxt = 1;
    end else if (m_mode == 1) begin
      if (m_pulse[0])      nxt = 0;
      else if (m_hit())    nxt = 3;
    end else begin
      nxt = 0;
    end
    if (pc != bp_addr) m_armed = 1'b1;
    else if (nxt != m_mode && (nxt == 1 || nxt == 2)) m_armed = 1'b0;
    if (en) begin
      m_exec = m_exec + 32'd1;
      m_pc   = (m_pc + 32'd4) & PC_MASK;
    end
    m_mode = nxt;
    m_pipe.push_back({btn_run, btn_step, btn_pause});
    seen = m_pipe.pop_front();
    for (int b = 0; b < 3; b++) begin
      m_pulse[b] = m_rose[b];
      m_rose[b]  = 1'b0;
      if (seen[b] != m_level[b]) begin
        m_agree_run[b]++;
        if (m_agree_run[b] == DB) begin
          m_level[b]     = seen[b];
          m_agree_run[b] = 0;
          m_rose[b]      = seen[b];
        end
      end else begin
        m_agree_run[b] = 0;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    n_vec++;
    cmp("model.state",    {30'd0, state},  m_mode[31:0]);
    cmp("model.cpu_en",   {31'd0, cpu_en}, {31'd0, m_en()});
    cmp("model.bp_hit",   {31'd0, bp_hit}, {31'd0, (m_mode == 3)});
    cmp("model.exec_cnt", exec_cnt,        m_exec);
  endtask

  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    pc = m_pc;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        run, step, pause, bpen;
    logic [31:0] addr;
    int          n;
    logic [1:0]  st;
    logic [31:0] ex;
    logic        en;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int cnt;
    // run step pause bpen addr n -> state exec cpu_en
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 8, 2'b01, 32'd0,  1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 4, 2'b01, 32'd4,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 1, 2'b11, 32'd4,  1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 8, 2'b11, 32'd4,  1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 8, 2'b01, 32'd4,  1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 7, 2'b01, 32'd11, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 2, 2'b11, 32'd12, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 8, 2'b11, 32'd12, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 8, 2'b01, 32'd12, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 8, 2'b00, 32'd20, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 3, 2'b00, 32'd20, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 8, 2'b00, 32'd20, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 8, 2'b10, 32'd20, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 1, 2'b00, 32'd21, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 8, 2'b00, 32'd21, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 9, 2'b00, 32'd22, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 8, 2'b00, 32'd22, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 9, 2'b00, 32'd23, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 8, 2'b00, 32'd23, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'h1C, 8, 2'b10, 32'd23, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 32'h1C, 1, 2'b00, 32'd24, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h1C, 8, 2'b00, 32'd24, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 8, 2'b01, 32'd24, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 8, 2'b01, 32'd32, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 1, 2'b11, 32'd32, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 8, 2'b00, 32'd32, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 8, 2'b00, 32'd32, 1'b0});

    // Reset state
    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; btn_pause = 1'b0;
    bp_en = 1'b0; bp_addr = 32'h10; pc = 32'd0;
    #1;
    n_vec++;
    cmp("reset.state", {30'd0, state}, 32'd0);
    cmp("reset.cpu_en", {31'd0, cpu_en}, 32'd0);
    cmp("reset.bp_hit", {31'd0, bp_hit}, 32'd0);
    cmp("reset.exec_cnt", exec_cnt, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; model_reset(); #1;

    // Run-press latency: RUN must appear DB_CYCLES+4 ticks after the press
    btn_run = 1'b1;
    cnt = 0;
    while (state != 2'b01 && cnt < 50) begin
      tick();
      cnt++;
    end
    n_vec++;
    cmp("latency.run_ticks", cnt, DB + 4);
    repeat (10) tick();
    n_vec++;
    cmp("run.exec_cnt", exec_cnt, 32'd10);

    // Asynchronous reset in mid-RUN, between clock edges
    #2; rst = 1'b1; #1;
    n_vec++;
    cmp("async_rst.state", {30'd0, state}, 32'd0);
    cmp("async_rst.cpu_en", {31'd0, cpu_en}, 32'd0);
    cmp("async_rst.exec_cnt", exec_cnt, 32'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    btn_run = 1'b0; pc = 32'd0; rst = 1'b0; #1;

    // Bounce rejection on step
    for (int i = 0; i < 20; i++) begin
      btn_step = ((i / 2) % 2 == 0);
      tick();
    end
    btn_step = 1'b0;
    repeat (10) tick();
    n_vec++;
    cmp("bounce.state", {30'd0, state}, 32'd0);
    cmp("bounce.exec_cnt", exec_cnt, 32'd0);

    // Table-driven directed sequences
    for (int r = 0; r < tbl.size(); r++) begin
      btn_run = tbl[r].run; btn_step = tbl[r].step; btn_pause = tbl[r].pause;
      bp_en = tbl[r].bpen; bp_addr = tbl[r].addr;
      repeat (tbl[r].n) tick();
      #1;
      n_vec++;
      cmp($sformatf("row%0d.state", r), {30'd0, state}, {30'd0, tbl[r].st});
      cmp($sformatf("row%0d.exec_cnt", r), exec_cnt, tbl[r].ex);
      cmp($sformatf("row%0d.cpu_en", r), {31'd0, cpu_en}, {31'd0, tbl[r].en});
    end

    // Randomized buttons and breakpoint settings against the model
    for (int blk = 0; blk < 4; blk++) begin
      bp_addr = 32'($urandom_range(0, 7) * 4);
      bp_en   = 1'($urandom_range(0, 1));
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 4) == 0) btn_run   = ~btn_run;
        if ($urandom_range(0, 4) == 0) btn_step  = ~btn_step;
        if ($urandom_range(0, 5) == 0) btn_pause = ~btn_pause;
        if ($urandom_range(0, 49) == 0) bp_en    = ~bp_en;
        tick();
      end
    end
    btn_run = 1'b0; btn_step = 1'b0; btn_pause = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debug_run_ctrl.md
Name: debug_run_ctrl

Overview:
- Board-level run controller for the RV32I core. Turns three raw push buttons (run, step, pause) into a CPU clock-enable.
- Supported modes: free-run, single-step, pause, and halt on a PC breakpoint.
- Each button gets its own synchroniser, debounce and rising-edge logic inside this block.
- Sits between the board I/O and the CPU top; the CPU gates every architectural state update with cpu_en.

Parameters:
- DB_CYCLES, 1000000: consecutive stable cycles required to accept a new button level (10 ms at 100 MHz; the bench uses 4).
- DB_WIDTH, 20: debounce counter width; must hold DB_CYCLES-1.
- PC_WIDTH, 32: width of pc and bp_addr.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- btn_run  in  1  raw, asynchronous button level.
- btn_step  in  1  raw, asynchronous button level.
- btn_pause  in  1  raw, asynchronous button level.
- bp_en  in  1  breakpoint enable (switch, treated as quasi-static).
- bp_addr  in  PC_WIDTH  breakpoint address.
- pc  in  PC_WIDTH  current CPU PC, registered in the CPU.
- cpu_en  out  1  CPU clock-enable; combinational from registered state plus pc.
- state  out  2  encoding: 00 PAUSE, 01 RUN, 10 STEP, 11 BREAK.
- bp_hit  out  1  high while in BREAK.
- exec_cnt  out  32  count of cycles with cpu_en=1.

Behaviour:
- Interface rules: one clock, clk; reset is asynchronous and active-high, rst. Every register clears on rst.
- Reset values: state=PAUSE, cpu_en=0, bp_hit=0, exec_cnt=0, armed=1. All synchronisers, debounced levels, counters and pulses are 0.
- Button path, per button, identical and independent:
  - Two-flop synchroniser.
  - Counter increments while sync output != debounced level; counter clears when they are equal.
  - When the counter equals DB_CYCLES-1 and still disagrees, the level takes the sync value on that edge and the counter clears.
  - Any bounce restarts the count.
  - A registered 1-cycle pulse fires on the debounced 0->1 transition only. Release produces no pulse.
  - Latency: raw high sampled at edge k gives the pulse high during cycle k+DB_CYCLES+2 (DB_CYCLES+2 edges later).
  - A held button produces exactly one pulse.
- Pulse priority when pulses coincide: pause > step > run.
- Breakpoint match: hit = bp_en && armed && (pc == bp_addr), full PC_WIDTH compare.
- armed flag:
  - Cleared on every transition into RUN or STEP.
  - Set on any cycle where pc != bp_addr.
  - Purpose: resuming at the breakpoint address executes it once instead of re-halting immediately.
- FSM transitions:
  - PAUSE: pause pulse -> PAUSE; step -> STEP; run -> RUN; otherwise stay.
  - RUN: pause -> PAUSE; else hit -> BREAK; else stay. Step and run pulses are ignored.
  - STEP: unconditionally -> PAUSE after exactly one cycle. Pulses arriving in STEP are dropped.
  - BREAK: pause -> PAUSE; step -> STEP; run -> RUN.
- cpu_en:
  - 1 in STEP.
  - 1 in RUN when hit=0.
  - 0 in RUN on the cycle hit=1, so the breakpoint instruction is not executed.
  - 0 in PAUSE and BREAK.
- STEP ignores breakpoints: exactly one enabled cycle per step pulse.
- bp_hit = (state == BREAK).
- exec_cnt increments by 1 on each edge where cpu_en=1; wraps 0xFFFFFFFF -> 0.
- Asynchronous rst mid-RUN or mid-debounce returns to PAUSE at once and discards pending and partial button counts.
- Changing bp_en or bp_addr while in RUN takes effect the same cycle.

Test Plan:
- Reset and debounce (DB_CYCLES=4): assert rst; release; drive btn_run high at edge 10 and hold -> one run pulse in cycle 16, state=01 from edge 17, cpu_en=1, exec_cnt counting; no second pulse while held.
- Bounce rejection: toggle btn_step high/low every 2 cycles for 20 cycles, then low -> no pulse, state stays 00, exec_cnt=0.
- Single step: from PAUSE give one clean btn_step press -> state 10 for exactly one cycle, cpu_en=1 for that cycle only, exec_cnt=1, back to 00. Three presses -> exec_cnt=3.
- Breakpoint: bp_en=1, bp_addr=0x00000010; RUN with pc stepping 0x0, 0x4, 0x8, 0xC, 0x10 -> cpu_en=0 on the pc=0x10 cycle, state=11 next edge, bp_hit=1, exec_cnt=4. Run press -> resumes: pc 0x10 executes, no re-halt until pc returns to 0x10 after leaving it.
- Priority and pause: while in RUN, press pause and step so their pulses coincide -> state=00, no STEP cycle. Pause press during RUN -> cpu_en=0 starting the cycle after the pulse.
- Async reset: assert rst mid-RUN between edges -> cpu_en, state and exec_cnt go to 0 immediately, without waiting for a clock edge.
